// File: rtl/bbs32_seq.sv
// bbs32_seq: sequences the bbs32 Blum-Blum-Shub core through one first run and
// then continuation runs, buffering every result word in a small output FIFO.
module bbs32_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cfg_p,
  input  logic [31:0]      cfg_q,
  input  logic [31:0]      cfg_seed,
  input  logic             cfg_load,
  input  logic             enable,
  output logic [31:0]      bbs_p,
  output logic [31:0]      bbs_q,
  output logic [31:0]      bbs_seed,
  output logic             bbs_start,
  output logic             bbs_keep_m,
  output logic             bbs_use_xnext,
  input  logic [63:0]      bbs_m,
  input  logic             bbs_m_valid,
  input  logic [31:0]      bbs_result,
  input  logic             bbs_result_valid,
  output logic [31:0]      rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             m_err,
  output logic [CNT_W-1:0] words_gen,
  output logic             busy
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_UNCFG = 3'd0,
    S_IDLE  = 3'd1,
    S_FIRST = 3'd2,
    S_NEXT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t         state_r;
  state_t         state_nxt;
  logic           start_nxt;
  logic           keep_nxt;
  logic           xnext_nxt;
  logic           push_s;
  logic           pop_s;
  logic           eval_s;
  logic           issue_ok_s;
  logic           core_active_s;
  logic           m_chk_s;
  logic [63:0]    m_expect_s;
  logic           first_pending_r;
  logic           m_checked_r;
  logic [31:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW:0]    count_r;
  logic [AW:0]    count_nxt;

  // The core counts as busy while it is being driven or is still presenting a result.
  assign core_active_s = bbs_start | bbs_result_valid;
  assign pop_s         = rnd_valid & rnd_ready;
  assign issue_ok_s    = enable && (count_r < DEPTH_C);
  assign m_expect_s    = {32'd0, bbs_p} * {32'd0, bbs_q};
  assign m_chk_s       = (state_r == S_FIRST) && bbs_m_valid && !m_checked_r && !cfg_load;
  assign rnd_data      = fifo_mem_r[rd_ptr_r];

  // Next-state and control decode; cfg_load overrides everything, including a result.
  always_comb begin
    state_nxt = state_r;
    start_nxt = bbs_start;
    keep_nxt  = bbs_keep_m;
    xnext_nxt = bbs_use_xnext;
    push_s    = 1'b0;
    eval_s    = 1'b0;
    if (cfg_load) begin
      start_nxt = 1'b0;
      keep_nxt  = 1'b0;
      xnext_nxt = 1'b0;
      if (core_active_s) begin
        state_nxt = S_GAP;
      end else begin
        state_nxt = S_IDLE;
      end
    end else begin
      case (state_r)
        S_UNCFG: state_nxt = S_UNCFG;
        S_IDLE:  eval_s = 1'b1;
        S_FIRST, S_NEXT: begin
          if (bbs_result_valid) begin
            push_s    = 1'b1;
            start_nxt = 1'b0;
            keep_nxt  = 1'b0;
            xnext_nxt = 1'b0;
            state_nxt = S_GAP;
          end else begin
            state_nxt = state_r;
          end
        end
        S_GAP: begin
          // start is already low here, so one GAP cycle is the minimum spacing
          if (!bbs_result_valid) begin
            eval_s = 1'b1;
          end else begin
            state_nxt = S_GAP;
          end
        end
        default: begin
          state_nxt = S_UNCFG;
          start_nxt = 1'b0;
          keep_nxt  = 1'b0;
          xnext_nxt = 1'b0;
        end
      endcase
      if (eval_s) begin
        state_nxt = S_IDLE;
        if (issue_ok_s) begin
          start_nxt = 1'b1;
          keep_nxt  = !first_pending_r;
          xnext_nxt = !first_pending_r;
          state_nxt = first_pending_r ? S_FIRST : S_NEXT;
        end else begin
          start_nxt = 1'b0;
        end
      end else begin
        eval_s = 1'b0;
      end
    end
  end

  // FIFO occupancy after this cycle's flush/push/pop.
  always_comb begin
    count_nxt = count_r;
    if (cfg_load) begin
      count_nxt = {(AW+1){1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nxt = count_r + (AW+1)'(1);
        2'b01:   count_nxt = count_r - (AW+1)'(1);
        default: count_nxt = count_r;
      endcase
    end
  end

  // State register and the status flags derived from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_UNCFG;
      bbs_start     <= 1'b0;
      bbs_keep_m    <= 1'b0;
      bbs_use_xnext <= 1'b0;
      busy          <= 1'b0;
      rnd_valid     <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      bbs_start     <= start_nxt;
      bbs_keep_m    <= keep_nxt;
      bbs_use_xnext <= xnext_nxt;
      busy          <= (state_nxt != S_UNCFG) && (state_nxt != S_IDLE);
      rnd_valid     <= (count_nxt != {(AW+1){1'b0}});
    end
  end

  // Configuration latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bbs_p    <= 32'd0;
      bbs_q    <= 32'd0;
      bbs_seed <= 32'd0;
    end else if (cfg_load) begin
      bbs_p    <= cfg_p;
      bbs_q    <= cfg_q;
      bbs_seed <= cfg_seed;
    end else begin
      bbs_p    <= bbs_p;
      bbs_q    <= bbs_q;
      bbs_seed <= bbs_seed;
    end
  end

  // Per-configuration bookkeeping: modulus check, first-run flag, word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_err           <= 1'b0;
      m_checked_r     <= 1'b0;
      first_pending_r <= 1'b0;
      words_gen       <= {CNT_W{1'b0}};
    end else if (cfg_load) begin
      m_err           <= 1'b0;
      m_checked_r     <= 1'b0;
      first_pending_r <= 1'b1;
      words_gen       <= {CNT_W{1'b0}};
    end else begin
      if (m_chk_s) begin
        m_checked_r <= 1'b1;
        if (bbs_m != m_expect_s) begin
          m_err <= 1'b1;
        end else begin
          m_err <= m_err;
        end
      end else begin
        m_checked_r <= m_checked_r;
      end
      if (push_s) begin
        first_pending_r <= 1'b0;
        if (words_gen != {CNT_W{1'b1}}) begin
          words_gen <= words_gen + CNT_W'(1);
        end else begin
          words_gen <= words_gen;
        end
      end else begin
        first_pending_r <= first_pending_r;
      end
    end
  end

  // FIFO storage and pointers; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 32'd0;
      end
    end else if (cfg_load) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      count_r <= count_nxt;
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= bbs_result;
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

endmodule

// File: tb/tb_bbs32_seq.sv
// Directed bench for bbs32_seq: a behavioural bbs32 core model answers the
// sequencer, and popped words are compared with a locally computed BBS stream.
module tb_bbs32_seq;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int LAT   = 4;
  localparam int LIMIT = 400;

  localparam int K_START  = 0;
  localparam int K_WORDS  = 1;
  localparam int K_IDLE   = 2;
  localparam int K_VALID  = 3;
  localparam int K_RESULT = 4;
  localparam int K_MERR   = 5;
  localparam int K_NEXT   = 6;
  localparam int K_FIRST  = 7;

  localparam logic [31:0] P1 = 32'd29711;
  localparam logic [31:0] Q1 = 32'd45543;
  localparam logic [31:0] S1 = 32'd56686;
  localparam logic [31:0] S2 = 32'd12345;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      cfg_p, cfg_q, cfg_seed;
  logic             cfg_load, enable, rnd_ready;
  logic [31:0]      bbs_p, bbs_q, bbs_seed;
  logic             bbs_start, bbs_keep_m, bbs_use_xnext;
  logic [63:0]      bbs_m;
  logic             bbs_m_valid;
  logic [31:0]      bbs_result;
  logic             bbs_result_valid;
  logic [31:0]      rnd_data;
  logic             rnd_valid;
  logic             m_err;
  logic [CNT_W-1:0] words_gen;
  logic             busy;

  int total = 0;
  int bad   = 0;

  bbs32_seq #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_p(cfg_p), .cfg_q(cfg_q), .cfg_seed(cfg_seed), .cfg_load(cfg_load), .enable(enable),
    .bbs_p(bbs_p), .bbs_q(bbs_q), .bbs_seed(bbs_seed),
    .bbs_start(bbs_start), .bbs_keep_m(bbs_keep_m), .bbs_use_xnext(bbs_use_xnext),
    .bbs_m(bbs_m), .bbs_m_valid(bbs_m_valid),
    .bbs_result(bbs_result), .bbs_result_valid(bbs_result_valid),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .m_err(m_err), .words_gen(words_gen), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference BBS step: 32 squarings mod m, collecting the LSB of each.
  function automatic void bbs_gen(input logic [63:0] xin, input logic [63:0] m,
                                  output logic [31:0] w, output logic [63:0] xout);
    logic [63:0] x;
    x = xin;
    w = 32'd0;
    for (int i = 0; i < 32; i++) begin
      x = (x * x) % m;
      w = {w[30:0], x[0]};
    end
    xout = x;
  endfunction

  // Core model: runs while start is held, aborts if start drops, one-cycle result pulse.
  logic        m_bad;
  logic [63:0] mdl_m, mdl_x, gen_x;
  logic [31:0] gen_w;
  logic        mdl_run, mdl_armed;
  int          mdl_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_run <= 1'b0; mdl_armed <= 1'b1; mdl_cnt <= 0;
      mdl_m <= 64'd1; mdl_x <= 64'd0;
      bbs_m <= 64'd0; bbs_m_valid <= 1'b0; bbs_result <= 32'd0; bbs_result_valid <= 1'b0;
    end else begin
      bbs_result_valid <= 1'b0;
      if (!bbs_start) begin
        mdl_run <= 1'b0; mdl_armed <= 1'b1; bbs_m_valid <= 1'b0;
      end else if (mdl_armed) begin
        mdl_armed <= 1'b0; mdl_run <= 1'b1; mdl_cnt <= LAT;
        if (!bbs_keep_m) mdl_m <= {32'd0, bbs_p} * {32'd0, bbs_q};
        if (!bbs_use_xnext) mdl_x <= {32'd0, bbs_seed};
      end else if (mdl_run) begin
        bbs_m_valid <= 1'b1;
        bbs_m <= mdl_m + {63'd0, m_bad};
        if (mdl_cnt == 0) begin
          bbs_gen(mdl_x, mdl_m, gen_w, gen_x);
          bbs_result <= gen_w; mdl_x <= gen_x;
          bbs_result_valid <= 1'b1; mdl_run <= 1'b0;
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end
    end
  end

  logic [31:0] exp1 [8];
  logic [31:0] exp2 [8];
  logic [63:0] tb_x;
  logic [31:0] tb_w;
  logic        start_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic cond(input int kind, input logic [63:0] val);
    case (kind)
      K_START:  cond = (bbs_start === 1'b1);
      K_WORDS:  cond = (64'(words_gen) === val);
      K_IDLE:   cond = (busy === 1'b0);
      K_VALID:  cond = (rnd_valid === 1'b1);
      K_RESULT: cond = (bbs_result_valid === 1'b1);
      K_MERR:   cond = (m_err === 1'b1);
      K_NEXT:   cond = (bbs_start === 1'b1) && (bbs_use_xnext === 1'b1);
      K_FIRST:  cond = (bbs_start === 1'b1) && (bbs_keep_m === 1'b0);
      default:  cond = 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int kind, input logic [63:0] val, input string tag);
    int n;
    n = 0;
    while (!cond(kind, val) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wait"}, 64'(n < LIMIT), 64'd1);
  endtask

  task automatic pop_one(input logic [31:0] exp, input string tag);
    wait_for(K_VALID, 64'd0, tag);
    check(tag, 64'(rnd_data), 64'(exp));
    rnd_ready = 1'b1;
    @(negedge clk);
    rnd_ready = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] p, input logic [31:0] q, input logic [31:0] s);
    cfg_p = p; cfg_q = q; cfg_seed = s; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic watch_start(input int cycles);
    start_seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      start_seen = start_seen | bbs_start;
    end
  endtask

  initial begin
    rst = 1'b1; cfg_load = 1'b0; enable = 1'b0; rnd_ready = 1'b0; m_bad = 1'b0;
    cfg_p = 32'd0; cfg_q = 32'd0; cfg_seed = 32'd0;
    tb_x = {32'd0, S1};
    for (int i = 0; i < 8; i++) begin bbs_gen(tb_x, 64'(P1) * 64'(Q1), tb_w, tb_x); exp1[i] = tb_w; end
    tb_x = {32'd0, S2};
    for (int i = 0; i < 8; i++) begin bbs_gen(tb_x, 64'(P1) * 64'(Q1), tb_w, tb_x); exp2[i] = tb_w; end

    // reset values
    repeat (3) @(negedge clk);
    check("rst_start", 64'(bbs_start), 64'd0);
    check("rst_keep_m", 64'(bbs_keep_m), 64'd0);
    check("rst_use_xnext", 64'(bbs_use_xnext), 64'd0);
    check("rst_bbs_p", 64'(bbs_p), 64'd0);
    check("rst_rnd_valid", 64'(rnd_valid), 64'd0);
    check("rst_m_err", 64'(m_err), 64'd0);
    check("rst_words_gen", 64'(words_gen), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // UNCFG ignores enable
    enable = 1'b1;
    watch_start(6);
    check("uncfg_start", 64'(start_seen), 64'd0);
    check("uncfg_busy", 64'(busy), 64'd0);

    // first configuration, first run then continuation runs
    do_load(P1, Q1, S1);
    check("load_p", 64'(bbs_p), 64'(P1));
    check("load_seed", 64'(bbs_seed), 64'(S1));
    check("load_idle_start", 64'(bbs_start), 64'd0);
    @(negedge clk);
    check("first_start", 64'(bbs_start), 64'd1);
    check("first_keep_m", 64'(bbs_keep_m), 64'd0);
    check("first_use_xnext", 64'(bbs_use_xnext), 64'd0);
    check("first_busy", 64'(busy), 64'd1);
    pop_one(exp1[0], "word0");
    check("m_ok", 64'(m_err), 64'd0);
    wait_for(K_NEXT, 64'd0, "next_run");
    check("next_keep_m", 64'(bbs_keep_m), 64'd1);
    pop_one(exp1[1], "word1");
    pop_one(exp1[2], "word2");

    // consumer stalled: exactly DEPTH words, then no further issue
    do_load(P1, Q1, S1);
    wait_for(K_WORDS, 64'd4, "fill");
    watch_start(30);
    check("full_no_start", 64'(start_seen), 64'd0);
    check("full_words", 64'(words_gen), 64'd4);
    pop_one(exp1[0], "stall_w0");
    wait_for(K_WORDS, 64'd5, "refill");
    watch_start(30);
    check("refill_no_start", 64'(start_seen), 64'd0);
    check("refill_words", 64'(words_gen), 64'd5);
    for (int i = 1; i < 5; i++) pop_one(exp1[i], "stall_wn");

    // wrong modulus from the core
    m_bad = 1'b1;
    do_load(P1, Q1, S1);
    wait_for(K_MERR, 64'd0, "m_err_set");
    rnd_ready = 1'b1;
    wait_for(K_WORDS, 64'd3, "m_err_continue");
    rnd_ready = 1'b0;
    check("m_err_sticky", 64'(m_err), 64'd1);
    m_bad = 1'b0;
    do_load(P1, Q1, S1);
    check("m_err_cleared", 64'(m_err), 64'd0);
    wait_for(K_WORDS, 64'd1, "m_ok_word");
    check("m_err_stays_clear", 64'(m_err), 64'd0);

    // reconfigure while NEXT is in flight
    wait_for(K_NEXT, 64'd0, "abort_next");
    do_load(P1, Q1, S2);
    check("abort_start", 64'(bbs_start), 64'd0);
    check("abort_words", 64'(words_gen), 64'd0);
    check("abort_flush", 64'(rnd_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd1);
    check("abort_seed", 64'(bbs_seed), 64'(S2));
    wait_for(K_START, 64'd0, "abort_restart");
    check("abort_keep_m", 64'(bbs_keep_m), 64'd0);
    check("abort_use_xnext", 64'(bbs_use_xnext), 64'd0);
    pop_one(exp2[0], "abort_w0");

    // cfg_load in the same cycle as a core result
    wait_for(K_RESULT, 64'd0, "coincide");
    cfg_p = P1; cfg_q = Q1; cfg_seed = S1; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    check("coincide_valid", 64'(rnd_valid), 64'd0);
    check("coincide_words", 64'(words_gen), 64'd0);
    pop_one(exp1[0], "coincide_w0");
    check("coincide_words1", 64'(words_gen), 64'd1);

    // enable dropped mid-word, then resumed
    wait_for(K_NEXT, 64'd0, "en_next");
    enable = 1'b0;
    wait_for(K_IDLE, 64'd0, "en_idle");
    check("en_words", 64'(words_gen), 64'd2);
    watch_start(20);
    check("en_no_start", 64'(start_seen), 64'd0);
    check("en_busy", 64'(busy), 64'd0);
    enable = 1'b1;
    wait_for(K_START, 64'd0, "en_resume");
    check("resume_keep_m", 64'(bbs_keep_m), 64'd1);
    check("resume_use_xnext", 64'(bbs_use_xnext), 64'd1);
    for (int i = 1; i < 3; i++) pop_one(exp1[i], "resume_w");

    // asynchronous reset in the middle of FIRST
    do_load(P1, Q1, S2);
    wait_for(K_FIRST, 64'd0, "rst_first");
    #2 rst = 1'b1;
    #1;
    check("arst_start", 64'(bbs_start), 64'd0);
    check("arst_valid", 64'(rnd_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_start(20);
    check("post_rst_start", 64'(start_seen), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_p", 64'(bbs_p), 64'd0);
    do_load(P1, Q1, S2);
    @(negedge clk);
    check("post_rst_first", 64'(bbs_start & ~bbs_keep_m), 64'd1);
    pop_one(exp2[0], "post_rst_w0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
